// File: rtl/jtframe_dwnld_pack.sv
// Packs the ROM-download byte stream into 16-bit masked SDRAM word writes through a small FIFO.
// Latency: completing byte at edge N -> FIFO after N+1 -> prog_we after N+2 (FIFO empty).
// Backpressure: prog_we held until prog_rdy; FIFO full drops words and sets sticky overflow.
//
// Ports: clk/rst_n (sync active-low); downloading/ioctl_addr/ioctl_dout/ioctl_wr byte stream in;
//        prog_addr/prog_data/prog_mask/prog_we/prog_rdy word handshake out; dwnld_busy, overflow, chksum status.
// Optional macro JTFRAME_DWNLD_CHKSUM_EN builds the 16-bit byte checksum; otherwise chksum is tied to 0.
module jtframe_dwnld_pack #(
    parameter int SDRAM_AW = 22,
    parameter int FIFO_AW  = 2,
    parameter bit SWAB     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                ioctl_wr,
    output logic [SDRAM_AW-1:0] prog_addr,
    output logic [15:0]         prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_rdy,
    output logic                dwnld_busy,
    output logic                overflow,
    output logic [15:0]         chksum
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [15:0]         data;
        logic [1:0]          mask;   // active-low byte enables, bit0 = data[7:0]
    } word_t;

    // Pending (partially assembled) word
    logic  pend_valid_q, pend_valid_d;
    word_t pend_q, pend_d;
    // One-word push stage between the packer and the FIFO
    logic  push_vld_q, push_vld_d;
    word_t push_q, push_d;
    // FIFO storage and pointers
    word_t              mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Registered outputs
    word_t prog_q, prog_d;
    logic  prog_we_q, prog_we_d;
    logic  busy_q, busy_d;
    logic  overflow_q, overflow_d;
    logic  dl_q;

    logic                byte_ok;
    logic                byte_hi;
    logic [SDRAM_AW-1:0] byte_w;
    logic                dl_rise, dl_fall;
    logic                pop, fifo_full, wr_en, drop;
    logic [FIFO_AW-1:0]  head_idx;
    logic [CW-1:0]       remaining;

    assign byte_w  = ioctl_addr[SDRAM_AW:1];
    // Bytes above the SDRAM window are ignored entirely (no word, no checksum)
    assign byte_ok = ioctl_wr && ((ioctl_addr >> (SDRAM_AW + 1)) == 25'd0);
    assign byte_hi = ioctl_addr[0] ^ SWAB;
    assign dl_rise = downloading & ~dl_q;
    assign dl_fall = ~downloading & dl_q;

    // Byte packer
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        push_vld_d   = 1'b0;
        push_d       = push_q;
        if (byte_ok) begin
            // A byte for a different word retires the current one with its partial mask
            if (pend_valid_q && (byte_w != pend_q.addr)) begin
                push_vld_d   = 1'b1;
                push_d       = pend_q;
                pend_valid_d = 1'b0;
            end
            if (!pend_valid_d) begin
                pend_d.addr = byte_w;
                pend_d.data = 16'h0000;
                pend_d.mask = 2'b11;
            end
            if (byte_hi) begin
                pend_d.data[15:8] = ioctl_dout;
                pend_d.mask[1]    = 1'b0;
            end else begin
                pend_d.data[7:0]  = ioctl_dout;
                pend_d.mask[0]    = 1'b0;
            end
            pend_valid_d = 1'b1;
            // A fresh word only has one half filled, so this never collides with the retire above
            if (pend_d.mask == 2'b00) begin
                push_vld_d   = 1'b1;
                push_d       = pend_d;
                pend_valid_d = 1'b0;
            end
        end else if (dl_fall && pend_valid_q) begin
            // End of download: flush the half-filled word
            push_vld_d   = 1'b1;
            push_d       = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    // FIFO control; a pop in the same cycle frees the slot for a push into a full FIFO
    always_comb begin
        pop        = prog_we_q & prog_rdy;
        fifo_full  = (cnt_q == CW'(DEPTH));
        wr_en      = push_vld_q && (!fifo_full || pop);
        drop       = push_vld_q && fifo_full && !pop;
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        cnt_d      = cnt_q + CW'(wr_en) - CW'(pop);
        overflow_d = overflow_q;
        if (dl_rise) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    // Output stage mirrors the FIFO head; entries written this edge are only visible next cycle
    always_comb begin
        head_idx  = rd_ptr_q + FIFO_AW'(pop);
        remaining = cnt_q - CW'(pop);
        prog_we_d = (remaining != '0);
        prog_d    = prog_we_d ? mem_q[head_idx] : '0;
        busy_d    = downloading | pend_valid_d | push_vld_d | (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            push_vld_q   <= 1'b0;
            push_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            prog_q       <= '0;
            prog_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            dl_q         <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            push_vld_q   <= push_vld_d;
            push_q       <= push_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            prog_q       <= prog_d;
            prog_we_q    <= prog_we_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            dl_q         <= downloading;
        end
    end

    // Storage needs no reset: cnt_q gates every read
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_ptr_q] <= push_q;
    end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
    logic [15:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = dl_rise ? 16'h0000 : chksum_q;
        if (byte_ok) chksum_d = chksum_d + {8'h00, ioctl_dout};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) chksum_q <= 16'h0000;
        else        chksum_q <= chksum_d;
    end

    assign chksum = chksum_q;
`else
    assign chksum = 16'h0000;
`endif

    assign prog_addr  = prog_q.addr;
    assign prog_data  = prog_q.data;
    assign prog_mask  = prog_q.mask;
    assign prog_we    = prog_we_q;
    assign dwnld_busy = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
module tb_jtframe_dwnld_pack;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          downloading = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          ioctl_wr = 1'b0;
    logic          prog_rdy = 1'b0;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          dwnld_busy;
    logic          overflow;
    logic [15:0]   chksum;

    always #5 clk = ~clk;

    jtframe_dwnld_pack #(.SDRAM_AW(AW), .FIFO_AW(2), .SWAB(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rdy(prog_rdy),
        .dwnld_busy(dwnld_busy), .overflow(overflow), .chksum(chksum)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Scoreboard: every accepted write must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en && prog_we && prog_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h mask=%b, expected no write",
                         prog_addr, prog_data, prog_mask);
            end else begin
                mon_e = exp_q.pop_front();
                if ({prog_addr, prog_data, prog_mask} !== mon_e) begin
                    errors++;
                    $display("FAIL write_data: got addr=%h data=%h mask=%b, expected addr=%h data=%h mask=%b",
                             prog_addr, prog_data, prog_mask, mon_e.addr, mon_e.data, mon_e.mask);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl;
        downloading = 1'b1;
        step();
    endtask

    task automatic end_dl;
        downloading = 1'b0;
        step();
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    // Bounded wait for the block to go idle; returns whether it did
    task automatic wait_idle(output bit idle);
        idle = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!dwnld_busy) begin
                idle = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got we=%b busy=%b, expected 0 0", prog_we, dwnld_busy);
        end
        checks++;
        if (overflow !== 1'b0 || chksum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_status: got ovf=%b chksum=%h, expected 0 0000", overflow, chksum);
        end
        checks++;
        if (prog_addr !== '0 || prog_data !== 16'h0000 || prog_mask !== 2'b00) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h mask=%b, expected all 0", prog_addr, prog_data, prog_mask);
        end
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_aligned;
        bit idle;
        logic [15:0] exp_ck;
        prog_rdy = 1'b1;
        start_dl();
        push_exp(22'd0, 16'h1234, 2'b00);
        wr_byte(25'd0, 8'h34);
        wr_byte(25'd1, 8'h12);   // sampled at edge N
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b0) begin errors++; $display("FAIL aligned_lat_n: got we=%b, expected 0", prog_we); end
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b0) begin errors++; $display("FAIL aligned_lat_n1: got we=%b, expected 0", prog_we); end
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b1) begin errors++; $display("FAIL aligned_lat_n2: got we=%b, expected 1", prog_we); end
        @(posedge clk);
        #1;
        end_dl();
        wait_idle(idle);
        checks++;
        if (!idle || exp_q.size() != 0) begin
            errors++;
            $display("FAIL aligned_drain: got idle=%b pending=%0d, expected 1 0", idle, exp_q.size());
        end
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        exp_ck = 16'h0046;
`else
        exp_ck = 16'h0000;
`endif
        checks++;
        if (chksum !== exp_ck) begin errors++; $display("FAIL aligned_chksum: got %h, expected %h", chksum, exp_ck); end
    endtask

    task automatic test_odd_tail;
        bit seen;
        prog_rdy = 1'b1;
        start_dl();
        push_exp(22'd8, 16'hBBAA, 2'b00);
        push_exp(22'd9, 16'h00CC, 2'b10);
        wr_byte(25'h10, 8'hAA);
        wr_byte(25'h11, 8'hBB);
        wr_byte(25'h12, 8'hCC);
        end_dl();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        // The last word is popped by the scoreboard just before its accepting edge
        checks++;
        if (!seen || dwnld_busy !== 1'b1) begin
            errors++;
            $display("FAIL odd_busy_before: got drained=%b busy=%b, expected 1 1", seen, dwnld_busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dwnld_busy !== 1'b0 || prog_we !== 1'b0) begin
            errors++;
            $display("FAIL odd_busy_after: got busy=%b we=%b, expected 0 0", dwnld_busy, prog_we);
        end
    endtask

    task automatic test_noncontig;
        bit idle;
        prog_rdy = 1'b1;
        start_dl();
        push_exp(22'd2, 16'h5500, 2'b01);
        push_exp(22'd4, 16'h0066, 2'b10);
        wr_byte(25'd5, 8'h55);
        wr_byte(25'd8, 8'h66);
        end_dl();
        wait_idle(idle);
        checks++;
        if (!idle || exp_q.size() != 0) begin
            errors++;
            $display("FAIL noncontig_drain: got idle=%b pending=%0d, expected 1 0", idle, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [AW+17:0] snap;
        int we_hi;
        bit idle;
        prog_rdy = 1'b0;
        start_dl();
        for (int i = 0; i < 12; i++) begin
            wr_byte(25'h20 + 25'(i), 8'(i + 1));
            if ((i % 2 == 1) && (i < 8)) push_exp(22'h10 + 22'(i / 2), {8'(i + 1), 8'(i)}, 2'b00);
        end
        repeat (3) step();
        checks++;
        if (prog_we !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_status: got we=%b ovf=%b, expected 1 1", prog_we, overflow);
        end
        checks++;
        if ({prog_addr, prog_data, prog_mask} !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_head: got addr=%h data=%h mask=%b, expected addr=%h data=%h mask=%b",
                     prog_addr, prog_data, prog_mask, exp_q[0].addr, exp_q[0].data, exp_q[0].mask);
        end
        snap = {prog_addr, prog_data, prog_mask};
        repeat (5) step();
        checks++;
        if ({prog_addr, prog_data, prog_mask} !== snap || prog_we !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got %h we=%b, expected %h we=1", {prog_addr, prog_data, prog_mask}, prog_we, snap);
        end
        prog_rdy = 1'b1;
        we_hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (prog_we === 1'b1) we_hi++;
        end
        @(negedge clk);
        checks++;
        if (we_hi != 4 || prog_we !== 1'b0) begin
            errors++;
            $display("FAIL bp_back_to_back: got we_high=%0d trailing_we=%b, expected 4 0", we_hi, prog_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained: got pending=%0d ovf=%b, expected 0 1", exp_q.size(), overflow);
        end
        end_dl();
        wait_idle(idle);
        checks++;
        if (!idle || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_ovf_hold: got idle=%b ovf=%b, expected 1 1", idle, overflow);
        end
        start_dl();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %b, expected 0", overflow); end
        end_dl();
        wait_idle(idle);
    endtask

    task automatic test_reset_mid;
        int we_cnt;
        prog_rdy = 1'b0;
        start_dl();
        for (int i = 0; i < 6; i++) wr_byte(25'h40 + 25'(i), 8'hE0 + 8'(i));
        step();
        rst_n       = 1'b0;
        downloading = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (prog_we !== 1'b0 || dwnld_busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags: got we=%b busy=%b ovf=%b, expected 0 0 0", prog_we, dwnld_busy, overflow);
        end
        prog_rdy = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prog_we === 1'b1) we_cnt++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (we_cnt != 0) begin errors++; $display("FAIL rstmid_stale: got %0d write cycles, expected 0", we_cnt); end
    endtask

`ifdef JTFRAME_DWNLD_CHKSUM_EN
    task automatic test_chksum;
        bit idle;
        prog_rdy = 1'b1;
        start_dl();
        for (int i = 0; i < 'h200; i++) begin
            wr_byte(25'(i), 8'hFF);
            if (i % 2 == 1) push_exp(22'(i / 2), 16'hFFFF, 2'b00);
        end
        end_dl();
        wait_idle(idle);
        checks++;
        if (!idle || exp_q.size() != 0 || chksum !== 16'hFE00) begin
            errors++;
            $display("FAIL chksum_sum: got idle=%b pending=%0d chksum=%h, expected 1 0 fe00", idle, exp_q.size(), chksum);
        end
        start_dl();
        checks++;
        if (chksum !== 16'h0000) begin errors++; $display("FAIL chksum_clear: got %h, expected 0000", chksum); end
        end_dl();
        wait_idle(idle);
    endtask
`endif

    initial begin
        test_reset();
        test_aligned();
        test_odd_tail();
        test_noncontig();
        test_backpressure();
        test_reset_mid();
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        test_chksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
